// File: rtl/demux_reg_nbit_1x32_if.sv
// -----------------------------------------------------------------------------
// demux_reg_nbit_1x32_if
// Write-request handshake bundle for the 1x32 register demux.
//   in_valid : request valid                 (master -> slave)
//   in_ready : slave can take a request      (slave  -> master)
//   in_sel   : target entry index 0..31      (master -> slave)
//   in_data  : N-bit write data              (master -> slave)
//   in_mask  : N-bit write enable, 1 = write (master -> slave)
// -----------------------------------------------------------------------------
interface demux_reg_nbit_1x32_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   in_sel;
  logic [N-1:0] in_data;
  logic [N-1:0] in_mask;

  modport master (
    output in_valid,
    output in_sel,
    output in_data,
    output in_mask,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_sel,
    input  in_data,
    input  in_mask,
    output in_ready
  );
endinterface

// File: rtl/demux_reg_nbit_1x32.sv
// -----------------------------------------------------------------------------
// demux_reg_nbit_1x32
// Write side of a 32-entry N-bit register file. A request (index, data, mask)
// is accepted into a one-deep decode stage (S1), where the index is held as a
// one-hot enable; on the following edge S1 commits a masked write into the
// selected entry. All entries are presented flat for the 32:1 read muxes.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   req      : write-request handshake (slave side)
//   hold     : keeps S1 from committing while high
//   clr      : synchronous clear of entries, valid bits and S1
//   busy     : S1 holds an uncommitted request
//   ent_vld  : bit i = entry i written since last reset/clr
//   ent_flat : entry i at bits [i*N +: N]
// -----------------------------------------------------------------------------
module demux_reg_nbit_1x32 #(
  parameter int N = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  demux_reg_nbit_1x32_if.slave        req,
  input  logic                        hold,
  input  logic                        clr,
  output logic                        busy,
  output logic [31:0]                 ent_vld,
  output logic [32*N-1:0]             ent_flat
);

  logic         w_ready;
  logic         w_accept;
  logic         w_commit;
  logic [31:0]  w_oh;

  logic         r_s1_vld;
  logic [31:0]  r_s1_oh;
  logic [N-1:0] r_s1_data;
  logic [N-1:0] r_s1_mask;

  logic [N-1:0] r_ent [32];
  logic [31:0]  r_ent_vld;

  // S1 can take a new request when empty or when it is draining this cycle;
  // clr blocks acceptance so a cleared cycle never loads fresh state.
  assign w_ready      = !clr && (!r_s1_vld || !hold);
  assign req.in_ready = w_ready;
  assign w_accept     = req.in_valid && w_ready;
  assign w_commit     = r_s1_vld && !hold && !clr;
  assign w_oh         = 32'd1 << req.in_sel;

  // Decode stage. An accept wins over the post-commit drain so back-to-back
  // requests stream at one per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      r_s1_vld  <= 1'b0;
      r_s1_oh   <= '0;
      r_s1_data <= '0;
      r_s1_mask <= '0;
    end else if (clr) begin
      r_s1_vld <= 1'b0;
    end else if (w_accept) begin
      r_s1_vld  <= 1'b1;
      r_s1_oh   <= w_oh;
      r_s1_data <= req.in_data;
      r_s1_mask <= req.in_mask;
    end else if (w_commit) begin
      r_s1_vld <= 1'b0;
    end
  end

  // Storage array with per-bit masked update of the single selected entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the array is built from flops and must read zero straight out of
      // reset, so every entry is reset explicitly rather than left to RAM init.
      for (int k = 0; k < 32; k++) r_ent[k] <= '0;
      r_ent_vld <= '0;
    end else if (clr) begin
      for (int k = 0; k < 32; k++) r_ent[k] <= '0;
      r_ent_vld <= '0;
    end else if (w_commit) begin
      for (int k = 0; k < 32; k++) begin
        if (r_s1_oh[k]) begin
          r_ent[k]     <= (r_ent[k] & ~r_s1_mask) | (r_s1_data & r_s1_mask);
          r_ent_vld[k] <= 1'b1;
        end
      end
    end
  end

  assign busy    = r_s1_vld;
  assign ent_vld = r_ent_vld;

  for (genvar g = 0; g < 32; g++) begin : g_flat
    assign ent_flat[g*N +: N] = r_ent[g];
  end

endmodule
